// File: rtl/sequenciador_batidas_pkg.sv
// Shared definitions for the metronome beat sequencer.
//   estado_e  : controller states (OCIOSO / ZERA / CONTA).
//   PulseCntW : width of the beat pulse-width down-counter.
// Optional feature macro: SEQUENCIADOR_CONTA_COMPASSOS_EN (measure counter).
package sequenciador_batidas_pkg;

  typedef enum logic [1:0] {
    StOcioso = 2'd0,
    StZera   = 2'd1,
    StConta  = 2'd2
  } estado_e;

  localparam int unsigned PulseCntW = 4;

endpackage

// File: rtl/sequenciador_batidas_if.sv
// Signal bundle between the beat sequencer and its environment.
//   inputs to sequencer : inicia, para, compasso, fim_depois, fim_antes
//   outputs of sequencer: conta_periodo, zera_periodo, batida, acento, indice_batida, aviso,
//                         ativo (and num_compassos when SEQUENCIADOR_CONTA_COMPASSOS_EN is defined)
// master: the side that drives requests and period flags; slave: the sequencer itself.
interface sequenciador_batidas_if #(
  parameter int unsigned CW = 3
);
  logic          inicia;
  logic          para;
  logic [CW-1:0] compasso;
  logic          fim_depois;
  logic          fim_antes;
  logic          conta_periodo;
  logic          zera_periodo;
  logic          batida;
  logic          acento;
  logic [CW-1:0] indice_batida;
  logic          aviso;
  logic          ativo;
`ifdef SEQUENCIADOR_CONTA_COMPASSOS_EN
  logic [7:0]    num_compassos;
`endif

  modport master (
`ifdef SEQUENCIADOR_CONTA_COMPASSOS_EN
    input  num_compassos,
`endif
    output inicia, para, compasso, fim_depois, fim_antes,
    input  conta_periodo, zera_periodo, batida, acento, indice_batida, aviso, ativo
  );

  modport slave (
`ifdef SEQUENCIADOR_CONTA_COMPASSOS_EN
    output num_compassos,
`endif
    input  inicia, para, compasso, fim_depois, fim_antes,
    output conta_periodo, zera_periodo, batida, acento, indice_batida, aviso, ativo
  );
endinterface

// File: rtl/sequenciador_batidas_detector_borda.sv
// Rising-edge detector with registered previous value and synchronous reset.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset (clears the previous-value register)
//   d_i     : level input
//   borda_o : high in the first cycle d_i is seen high after being low
module detector_borda (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic borda_o
);
  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= d_i;
    end
  end

  assign borda_o = d_i & ~prev_q;
endmodule

// File: rtl/sequenciador_batidas.sv
// Metronome beat sequencer. Consumes the period counter's end flags and produces
// fixed-width beat pulses, accenting beat 0 of each measure.
//   clock  : system clock, rising edge
//   zera_s : synchronous active-high reset, priority over everything
//   bus_io : sequenciador_batidas_if.slave (start/stop, compasso, period flags, beat outputs)
// Optional feature macro: SEQUENCIADOR_CONTA_COMPASSOS_EN adds bus_io.num_compassos, a
// saturating count of completed measures since the last start.
module sequenciador_batidas
  import sequenciador_batidas_pkg::*;
#(
  parameter int unsigned PULSE_W = 4,
  parameter int unsigned CW      = 3
) (
  input logic                          clock,
  input logic                          zera_s,
  sequenciador_batidas_if.slave        bus_io
);
  localparam int unsigned IdxW = CW + 1;

  estado_e              st_q, st_d;
  logic [PulseCntW-1:0] cnt_q, cnt_d;
  logic [CW-1:0]        idx_q, idx_d;
  logic [CW-1:0]        comp_q, comp_d;
  logic                 acc_q, acc_d;
  logic                 aviso_q, aviso_d;

  logic                 tick, pre;
  logic                 beat, inicio;
  logic [IdxW-1:0]      idx_inc;
  logic [CW-1:0]        idx_prox;

  detector_borda u_borda_depois (
    .clk_i   (clock),
    .rst_i   (zera_s),
    .d_i     (bus_io.fim_depois),
    .borda_o (tick)
  );

  detector_borda u_borda_antes (
    .clk_i   (clock),
    .rst_i   (zera_s),
    .d_i     (bus_io.fim_antes),
    .borda_o (pre)
  );

  // Extra bit keeps the compare with comp_q exact when comp_q is the max value.
  assign idx_inc  = {1'b0, idx_q} + IdxW'(1);
  assign idx_prox = (idx_inc == {1'b0, comp_q}) ? '0 : idx_inc[CW-1:0];

  always_comb begin
    st_d    = st_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - PulseCntW'(1) : '0;
    idx_d   = idx_q;
    comp_d  = comp_q;
    acc_d   = acc_q;
    aviso_d = 1'b0;
    beat    = 1'b0;
    inicio  = 1'b0;

    unique case (st_q)
      StOcioso: begin
        if (bus_io.inicia && !bus_io.para) begin
          st_d   = StZera;
          inicio = 1'b1;
          comp_d = (bus_io.compasso == '0) ? CW'(1) : bus_io.compasso;
        end
      end
      StZera: begin
        st_d  = StConta;
        beat  = 1'b1;
        idx_d = '0;
      end
      StConta: begin
        if (bus_io.para) begin
          // Stop truncates any pulse in progress; the index is kept.
          st_d  = StOcioso;
          cnt_d = '0;
        end else begin
          aviso_d = pre;
          if (tick) begin
            beat  = 1'b1;
            idx_d = idx_prox;
          end
        end
      end
      default: st_d = StOcioso;
    endcase

    // A beat (re)loads the full width, so a retrigger extends the pulse seamlessly.
    if (beat) begin
      cnt_d = PulseCntW'(PULSE_W);
      acc_d = (idx_d == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (zera_s) begin
      st_q    <= StOcioso;
      cnt_q   <= '0;
      idx_q   <= '0;
      comp_q  <= CW'(1);
      acc_q   <= 1'b0;
      aviso_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      comp_q  <= comp_d;
      acc_q   <= acc_d;
      aviso_q <= aviso_d;
    end
  end

  assign bus_io.conta_periodo = (st_q == StConta);
  assign bus_io.ativo         = (st_q == StConta);
  assign bus_io.zera_periodo  = (st_q == StZera);
  assign bus_io.batida        = (cnt_q != '0);
  assign bus_io.acento        = (cnt_q != '0) & acc_q;
  assign bus_io.indice_batida = idx_q;
  assign bus_io.aviso         = aviso_q;

`ifdef SEQUENCIADOR_CONTA_COMPASSOS_EN
  logic [7:0] ncomp_q, ncomp_d;

  // Only non-start beats that wrap to index 0 close a measure.
  always_comb begin
    ncomp_d = ncomp_q;
    if (inicio) begin
      ncomp_d = '0;
    end else if (beat && (st_q == StConta) && (idx_d == '0) && (ncomp_q != 8'hFF)) begin
      ncomp_d = ncomp_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (zera_s) begin
      ncomp_q <= '0;
    end else begin
      ncomp_q <= ncomp_d;
    end
  end

  assign bus_io.num_compassos = ncomp_q;
`endif
endmodule

// File: tb/tb_sequenciador_batidas.sv
// Bench for sequenciador_batidas: directed scenarios followed by random stimulus, every cycle
// compared against a cycle-number based reference model of the beat rules.
// Optional feature macro: SEQUENCIADOR_CONTA_COMPASSOS_EN enables measure-counter checks.
module tb_sequenciador_batidas;
  localparam int unsigned PW = 4;
  localparam int unsigned CWB = 3;

  logic clock;
  logic zera_s;

  sequenciador_batidas_if #(.CW(CWB)) sq_if ();

  sequenciador_batidas #(
    .PULSE_W (PW),
    .CW      (CWB)
  ) dut (
    .clock  (clock),
    .zera_s (zera_s),
    .bus_io (sq_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: run phase, measure size, last beat index, and the cycle number of the
  // last cycle in which the current pulse should still be visible.
  int cyc = 0;
  int m_phase = 0;  // 0 idle, 1 clearing the period counter, 2 counting
  int m_last = 0;
  int m_idx = 0;
  int m_comp = 1;
  int m_ncomp = 0;
  bit m_acc = 0;
  bit m_aviso = 0;
  bit m_fd_prev = 0;
  bit m_fa_prev = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    bit tick, pre, beat, bat;
    int nidx, n;
    n = cyc + 1;
    tick = sq_if.fim_depois && !m_fd_prev;
    pre = sq_if.fim_antes && !m_fa_prev;
    beat = 0;
    nidx = 0;
    m_aviso = 0;
    if (zera_s) begin
      m_phase = 0; m_last = n - 1; m_acc = 0; m_idx = 0; m_ncomp = 0;
      m_fd_prev = 0; m_fa_prev = 0;
    end else begin
      if (m_phase == 0) begin
        if (sq_if.inicia && !sq_if.para) begin
          m_phase = 1;
          m_comp = (sq_if.compasso == 0) ? 1 : int'(sq_if.compasso);
          m_ncomp = 0;
        end
      end else if (m_phase == 1) begin
        m_phase = 2;
        beat = 1;
        nidx = 0;
      end else if (sq_if.para) begin
        m_phase = 0;
        m_last = n - 1;
      end else begin
        m_aviso = pre;
        if (tick) begin
          beat = 1;
          nidx = (m_idx + 1) % m_comp;
          if (nidx == 0 && m_ncomp < 255) m_ncomp++;
        end
      end
      if (beat) begin
        m_idx = nidx;
        m_acc = (nidx == 0);
        m_last = n + PW - 1;
      end
      m_fd_prev = sq_if.fim_depois;
      m_fa_prev = sq_if.fim_antes;
    end
    @(posedge clock);
    #1;
    cyc = n;
    bat = (n <= m_last);
    chk("conta_periodo", 32'(sq_if.conta_periodo), 32'(m_phase == 2));
    chk("ativo", 32'(sq_if.ativo), 32'(m_phase == 2));
    chk("zera_periodo", 32'(sq_if.zera_periodo), 32'(m_phase == 1));
    chk("batida", 32'(sq_if.batida), 32'(bat));
    chk("acento", 32'(sq_if.acento), 32'(bat && m_acc));
    chk("indice_batida", 32'(sq_if.indice_batida), 32'(m_idx));
    chk("aviso", 32'(sq_if.aviso), 32'(m_aviso));
`ifdef SEQUENCIADOR_CONTA_COMPASSOS_EN
    chk("num_compassos", 32'(sq_if.num_compassos), 32'(m_ncomp));
`endif
  endtask

  // fim_depois one cycle in every per, fim_antes a quarter period in.
  task automatic run_periodic(input int ncyc, input int per);
    for (int i = 0; i < ncyc; i++) begin
      sq_if.fim_depois = (i % per == per - 1);
      sq_if.fim_antes = (i % per == per / 4 - 1);
      step();
    end
    sq_if.fim_depois = 1'b0;
    sq_if.fim_antes = 1'b0;
  endtask

  task automatic start(input logic [CWB-1:0] comp);
    sq_if.compasso = comp;
    sq_if.inicia = 1'b1;
    step();
    sq_if.inicia = 1'b0;
    sq_if.compasso = 3'd5;  // must be ignored from here on
  endtask

  initial begin
    int rises, highs;
    logic prev_b;
    zera_s = 1'b1;
    sq_if.inicia = 1'b0;
    sq_if.para = 1'b0;
    sq_if.compasso = 3'd3;
    sq_if.fim_depois = 1'b0;
    sq_if.fim_antes = 1'b0;

    // Reset, idle, start with compasso=3, then several measures of ticks.
    step(); step();
    zera_s = 1'b0;
    for (int i = 0; i < 3; i++) step();
    start(3'd3);
    run_periodic(45, 10);

    // inicia while counting is ignored.
    sq_if.inicia = 1'b1;
    step(); step();
    sq_if.inicia = 1'b0;
    run_periodic(12, 6);

    // fim_depois held high five cycles: exactly one beat.
    for (int i = 0; i < 6; i++) step();
    rises = 0;
    prev_b = sq_if.batida;
    for (int i = 0; i < 10; i++) begin
      sq_if.fim_depois = (i < 5);
      step();
      if (sq_if.batida && !prev_b) rises++;
      prev_b = sq_if.batida;
    end
    chk("hold_high_one_beat", 32'(rises), 32'd1);

    // para together with a tick: no beat, stop, index retained.
    sq_if.fim_depois = 1'b0;
    for (int i = 0; i < 6; i++) step();
    sq_if.fim_depois = 1'b1;
    sq_if.para = 1'b1;
    step();
    sq_if.fim_depois = 1'b0;
    sq_if.para = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // compasso=0 behaves as one beat per measure: every beat accented.
    start(3'd0);
    run_periodic(40, 8);

    // Synchronous reset in the second cycle of a pulse, then a fresh start.
    sq_if.fim_depois = 1'b1;
    step();
    sq_if.fim_depois = 1'b0;
    step();
    zera_s = 1'b1;
    step();
    zera_s = 1'b0;
    step();
    start(3'd4);
    run_periodic(50, 10);

    // Retrigger two cycles after a beat: one continuous six-cycle pulse.
    for (int i = 0; i < 6; i++) step();
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      sq_if.fim_depois = (i == 0 || i == 2);
      step();
      if (sq_if.batida) highs++;
    end
    chk("retrigger_width", 32'(highs), 32'd6);
    sq_if.fim_depois = 1'b0;

    // para and inicia together while idle: stay idle.
    sq_if.para = 1'b1;
    step();
    sq_if.inicia = 1'b1;
    step(); step();
    sq_if.inicia = 1'b0;
    sq_if.para = 1'b0;
    step();

`ifdef SEQUENCIADOR_CONTA_COMPASSOS_EN
    start(3'd2);
    run_periodic(140, 10);
    chk("num_compassos_7", 32'(sq_if.num_compassos), 32'd7);
    sq_if.para = 1'b1;
    step();
    sq_if.para = 1'b0;
    start(3'd1);
    run_periodic(520, 2);
    chk("num_compassos_sat", 32'(sq_if.num_compassos), 32'd255);
    sq_if.para = 1'b1;
    step();
    sq_if.para = 1'b0;
`endif

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      zera_s = ($urandom_range(0, 199) == 0);
      sq_if.inicia = ($urandom_range(0, 14) == 0);
      sq_if.para = ($urandom_range(0, 39) == 0);
      sq_if.compasso = 3'($urandom_range(0, 7));
      sq_if.fim_depois = ($urandom_range(0, 5) == 0);
      sq_if.fim_antes = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sequenciador_batidas.md
Name: sequenciador_batidas

Overview:
- Downstream stage of the period counter: consumes its end-of-period flag (fim_depois) and early-warning flag (fim_antes).
- Turns them into metronome beat pulses of fixed width, with an accent on beat 0 of each measure.
- Drives the period counter's conta/zera_s through conta_periodo/zera_periodo.
- Sits between the period counter and the LED/buzzer output logic.

Parameters:
- PULSE_W, 4, width of batida/acento pulse in clock cycles (1..15).
- CW, 3, width of compasso and indice_batida; max beats per measure = 2^CW-1.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- zera_s  in  1  synchronous active-high reset.
- inicia  in  1  start request, single-cycle pulse or level.
- para  in  1  stop request.
- compasso  in  CW  beats per measure; sampled only when a start is accepted.
- fim_depois  in  1  level from the period counter, high while Q==M-1.
- fim_antes  in  1  level from the period counter, high while Q==M/4-1.
- conta_periodo  out  1  enable to the period counter.
- zera_periodo  out  1  one-cycle sync clear to the period counter.
- batida  out  1  beat pulse, PULSE_W cycles.
- acento  out  1  high together with batida when the beat index is 0.
- indice_batida  out  CW  index of the most recent beat.
- aviso  out  1  one-cycle pre-beat warning.
- ativo  out  1  high while in the CONTA state.

Behaviour:
- Reset: zera_s=1 at a rising edge forces state OCIOSO, all outputs 0, pulse counter 0, index 0, edge-detect registers 0. This holds mid-operation too; zera_s has priority over every other input.
- States:
  - OCIOSO: conta_periodo=0, ativo=0. inicia=1 and para=0 → ZERA; latch comp_reg = (compasso==0 ? 1 : compasso).
  - ZERA (exactly 1 cycle): zera_periodo=1, conta_periodo=0. Next state CONTA. Fires beat 0 (start beat).
  - CONTA: conta_periodo=1, ativo=1. para=1 → OCIOSO. inicia is ignored here and does not restart or re-sample compasso.
- Edge detection:
  - tick = fim_depois & ~fim_depois_d, where fim_depois_d is registered each cycle.
  - pre = fim_antes & ~fim_antes_d, built the same way.
  - The edge is required because fim_depois stays high while the counter is paused.
- Beat event: the ZERA→CONTA transition, or tick=1 while in CONTA with para=0.
- Registered beat outputs on a beat event:
  - From the next edge, batida=1 for exactly PULSE_W cycles.
  - indice_batida takes the new index.
  - acento = (new index==0) for the same PULSE_W cycles.
  - Latency: batida rises 1 cycle after the cycle in which tick is high.
- Index rules:
  - Start beat index is 0.
  - Each subsequent beat index = (prev+1 == comp_reg) ? 0 : prev+1.
  - comp_reg=1 makes every beat accented.
- Retrigger: a beat event while batida is still high restarts the width count at PULSE_W. batida stays high continuously and acento is recomputed.
- aviso: equals pre registered, only in CONTA. One-cycle pulse, otherwise 0.
- Stop:
  - Next cycle: state OCIOSO, conta_periodo=0, ativo=0, batida=0, acento=0 (any pulse in progress is truncated).
  - indice_batida holds its last value until the next start.
- Simultaneous events:
  - para and tick in the same cycle: para wins, no beat.
  - para and inicia in OCIOSO: stay in OCIOSO.
  - zera_s with anything: reset.
- Arithmetic: the pulse counter is 4 bits and saturates at 0. The index wraps only by comparison with comp_reg and never overflows CW bits.

Optional Feature:
- Macro SEQUENCIADOR_CONTA_COMPASSOS_EN.
- Defined:
  - Extra output num_compassos [7:0].
  - Increments when a beat with new index 0 fires, excluding the start beat.
  - Saturates at 255.
  - Cleared by zera_s and on entry to ZERA.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package/header sequenciador_pkg:
  - State encoding constants OCIOSO=2'd0, ZERA=2'd1, CONTA=2'd2.
  - PULSE_CNT_W=4.
- Sub-module detector_borda: rising-edge detector, 1-bit in, registered previous value, sync reset. Instantiated twice, for fim_depois and fim_antes.

Test Plan (PULSE_W=4, compasso=3, fim_depois high 1 cycle every 10):
- Reset, then inicia at cycle 5 → zera_periodo=1 at cycle 6 only. batida=acento=1 cycles 7-10, indice=0. conta_periodo=1 from cycle 7.
- Three subsequent ticks:
  - indice goes 1, 2, 0.
  - acento is high only on the index-0 beat.
  - Each batida is exactly 4 cycles, starting 1 cycle after its tick.
- Hold fim_depois high 5 cycles → exactly one beat. compasso=0 at start → every beat accented, indice stays 0.
- para asserted the same cycle as a tick → no beat. Next cycle: ativo=0, conta_periodo=0, batida=0. indice is retained.
- zera_s asserted mid-pulse (2nd cycle of batida) → next edge all outputs 0, state OCIOSO. inicia afterwards restarts at beat 0.
- Tick 2 cycles after a beat (retrigger) → batida stays high 6 cycles total. With the macro: 7 measures → num_compassos=7; forced saturation at 255 holds.
